// File: rtl/ibex_lbist_mc_ctrl.sv
// ibex_lbist_mc_ctrl: round-robin multi-channel logic-BIST controller with LFSR patterns, per-channel MISRs and an APB register file
module ibex_lbist_mc_ctrl #(
  parameter int unsigned NumCh       = 2,
  parameter int unsigned Width       = 32,
  parameter int unsigned OpW         = 4,
  parameter logic [31:0] LfsrPoly    = 32'h80200003,
  parameter bit          AbortOnWake = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   core_sleep_i,
  input  logic                   sim_fault_inject_i,
  input  logic [31:0]            paddr_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [31:0]            pwdata_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic                   bist_active_o,
  output logic [1:0]             bist_ch_o,
  output logic [Width-1:0]       bist_op_a_o,
  output logic [Width-1:0]       bist_op_b_o,
  output logic [OpW-1:0]         bist_opsel_o,
  input  logic [NumCh*Width-1:0] bist_resp_i,
  output logic                   bist_done_o,
  output logic                   bist_error_irq_o
);
  localparam logic [2:0] Nch = 3'(NumCh);
  typedef enum logic [2:0] {IDLE, SEED, RUN, CHECK, DONE} state_e;
  state_e state;
  logic [Width-1:0] lfsr, misr, seed, resp, poly, lfsr_rev, lfsr_nx, misr_nx;
  logic [Width-1:0] golden [4];
  logic [Width-1:0] sig [4];
  logic [15:0] pcnt, cnt;
  logic [1:0] ch, idx;
  logic [3:0] fail, fail_nx;
  logic [7:0] a;
  logic [31:0] rdata;
  logic en, irq_en, done, hw_run, sleep_q, irq;
  logic acc, busy, err, wr_ok, start, rise, abort, last_ch;
  logic is_ctrl, is_stat, is_pcnt, is_seed, is_gold, is_sig, mapped;
  logic unused_addr;
  assign unused_addr = ^paddr_i[31:8];
  assign poly = LfsrPoly[Width-1:0];
  assign resp = bist_resp_i[32'(ch)*Width +: Width];
  for (genvar i = 0; i < Width; i++) begin : g_rev
    assign lfsr_rev[i] = lfsr[Width-1-i];
  end
  assign lfsr_nx = {lfsr[Width-2:0], 1'b0} ^ (lfsr[Width-1] ? poly : '0);
  assign misr_nx = {misr[Width-2:0], 1'b0} ^ (misr[Width-1] ? poly : '0) ^ resp
                   ^ {{(Width-1){1'b0}}, sim_fault_inject_i};
  assign a       = paddr_i[7:0];
  assign idx     = a[3:2];
  assign acc     = psel_i & penable_i;
  assign busy    = state != IDLE;
  assign is_ctrl = a == 8'h00;
  assign is_stat = a == 8'h04;
  assign is_pcnt = a == 8'h08;
  assign is_seed = a == 8'h0C;
  assign is_gold = a[7:4] == 4'h2 && a[1:0] == 2'b00 && {1'b0, idx} < Nch;
  assign is_sig  = a[7:4] == 4'h3 && a[1:0] == 2'b00 && {1'b0, idx} < Nch;
  assign mapped  = is_ctrl | is_stat | is_pcnt | is_seed | is_gold | is_sig;
  assign err     = acc & (~mapped | (pwrite_i & busy & (is_ctrl | is_pcnt | is_seed | is_gold)));
  assign wr_ok   = acc & pwrite_i & ~err;
  assign start   = wr_ok & is_ctrl & pwdata_i[1];
  assign rise    = core_sleep_i & ~sleep_q;
  assign abort   = AbortOnWake & hw_run & busy & ~core_sleep_i;
  assign last_ch = {1'b0, ch} >= Nch - 3'd1;
  always_comb begin
    rdata = is_ctrl ? {29'b0, irq_en, 1'b0, en} :
            is_stat ? {20'b0, fail, 6'b0, done, busy} :
            is_pcnt ? {16'b0, pcnt} :
            is_seed ? 32'(seed) :
            is_gold ? 32'(golden[idx]) :
            is_sig  ? 32'(sig[idx]) : 32'b0;
  end
  always_comb begin
    fail_nx = fail & ~((wr_ok & is_stat) ? pwdata_i[11:8] : 4'b0);
    if (state == CHECK && !abort && misr != golden[ch]) fail_nx[ch] = 1'b1;
  end
  assign prdata_o         = (acc & ~err) ? rdata : 32'b0;
  assign pready_o         = 1'b1;
  assign pslverr_o        = err;
  assign bist_active_o    = busy;
  assign bist_ch_o        = busy ? ch : 2'b0;
  assign bist_op_a_o      = state == RUN ? lfsr : '0;
  assign bist_op_b_o      = state == RUN ? lfsr_rev : '0;
  assign bist_opsel_o     = state == RUN ? lfsr[OpW-1:0] : '0;
  assign bist_done_o      = state == DONE;
  assign bist_error_irq_o = irq;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      lfsr    <= '0;
      misr    <= '0;
      seed    <= Width'(1);
      pcnt    <= 16'd256;
      cnt     <= '0;
      ch      <= '0;
      fail    <= '0;
      en      <= 1'b0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      hw_run  <= 1'b0;
      sleep_q <= 1'b0;
      irq     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        golden[i] <= '0;
        sig[i]    <= '0;
      end
    end else begin
      sleep_q <= core_sleep_i;
      fail    <= fail_nx;
      irq     <= irq_en & |fail_nx;
      if (wr_ok & is_ctrl) {irq_en, en} <= {pwdata_i[2], pwdata_i[0]};
      if (wr_ok & is_stat & pwdata_i[1]) done <= 1'b0;
      if (wr_ok & is_pcnt) pcnt <= pwdata_i[15:0];
      if (wr_ok & is_seed) seed <= pwdata_i[Width-1:0];
      if (wr_ok & is_gold) golden[idx] <= pwdata_i[Width-1:0];
      if (abort) state <= IDLE;
      else begin
        case (state)
          IDLE: if (start | (rise & en)) begin
            state  <= SEED;
            hw_run <= ~start;
            ch     <= '0;
          end
          SEED: begin
            lfsr  <= seed == '0 ? Width'(1) : seed;
            misr  <= '0;
            cnt   <= pcnt;
            state <= pcnt != 16'd0 ? RUN : CHECK;
          end
          RUN: begin
            lfsr <= lfsr_nx;
            misr <= misr_nx;
            cnt  <= cnt - 16'd1;
            if (cnt == 16'd1) state <= CHECK;
          end
          CHECK: begin
            sig[ch] <= misr;
            if (!last_ch) ch <= ch + 2'd1;
            state <= last_ch ? DONE : SEED;
          end
          DONE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ibex_lbist_mc_ctrl.sv
// tb_ibex_lbist_mc_ctrl: directed checks of the LBIST controller with hand-computed signatures
module tb_ibex_lbist_mc_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, sleep = 1'b0, fault = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, prdata, opa, opb, rd;
  logic pready, pslverr, active, done, irq, err;
  logic [1:0] ch;
  logic [3:0] opsel;
  logic [63:0] resp;
  int checks = 0, failures = 0, busy_cnt, done_at;
  logic irq_h [128];
  logic [31:0] opa_h [128];
  logic [31:0] opb_h [128];
  logic [3:0] opsel_h [128];
  logic [1:0] ch_h [128];
  assign resp = {~(opa ^ opb), opa ^ opb};
  always #5 clk = ~clk;
  ibex_lbist_mc_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .core_sleep_i(sleep), .sim_fault_inject_i(fault),
    .paddr_i(paddr), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .bist_active_o(active), .bist_ch_o(ch), .bist_op_a_o(opa), .bist_op_b_o(opb),
    .bist_opsel_o(opsel), .bist_resp_i(resp), .bist_done_o(done), .bist_error_irq_o(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic apb_write(input logic [31:0] ad, input logic [31:0] d, output logic e);
    @(negedge clk);
    paddr = ad; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 e = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask
  task automatic apb_read(input logic [31:0] ad, output logic [31:0] d, output logic e);
    @(negedge clk);
    paddr = ad; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; e = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask
  task automatic watch(input int ncyc, input int fault_at, input int wake_at);
    busy_cnt = 0;
    done_at = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (active) busy_cnt++;
      if (done) done_at = n;
      irq_h[n] = irq; opa_h[n] = opa; opb_h[n] = opb; opsel_h[n] = opsel; ch_h[n] = ch;
      fault = (n == fault_at);
      if (n == wake_at) sleep = 1'b0;
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_prdata", prdata, 0);
    rst_n = 1'b1;
    apb_read(32'h08, rd, err); chk("rst_pcnt", rd, 256);
    apb_read(32'h0C, rd, err); chk("rst_seed", rd, 1);
    apb_read(32'h00, rd, err); chk("rst_ctrl", rd, 0);
    apb_read(32'h04, rd, err); chk("rst_status", rd, 0);
    apb_read(32'h30, rd, err); chk("rst_sig0", rd, 0);
    apb_write(32'h20, 32'h50C0000A, err);
    apb_write(32'h24, 32'h50000005, err);
    apb_write(32'h08, 4, err);
    apb_write(32'h00, 32'h2, err);
    watch(20, 0, 0);
    chk("nom_busy_cycles", busy_cnt, 13);
    chk("nom_done_cycle", done_at, 13);
    chk("nom_op_a", opa_h[2], 32'h1);
    chk("nom_op_b", opb_h[2], 32'h80000000);
    chk("nom_opsel", 32'(opsel_h[2]), 1);
    chk("nom_op_a_run2", opa_h[3], 32'h2);
    chk("nom_ch1", 32'(ch_h[8]), 1);
    chk("nom_irq", 32'(irq_h[14]), 0);
    apb_read(32'h04, rd, err); chk("nom_status", rd, 32'h2);
    apb_read(32'h30, rd, err); chk("nom_sig0", rd, 32'h50C0000A);
    apb_read(32'h34, rd, err); chk("nom_sig1", rd, 32'h50000005);
    apb_read(32'h00, rd, err); chk("nom_ctrl_start_reads0", rd, 0);
    apb_write(32'h04, 32'h2, err);
    apb_write(32'h00, 32'h6, err);
    watch(20, 8, 0);
    chk("flt_irq_c12", 32'(irq_h[12]), 0);
    chk("flt_irq_c13", 32'(irq_h[13]), 1);
    apb_read(32'h04, rd, err); chk("flt_status", rd, 32'h202);
    apb_read(32'h34, rd, err); chk("flt_sig1", rd, 32'h5000000D);
    apb_read(32'h30, rd, err); chk("flt_sig0", rd, 32'h50C0000A);
    chk("flt_irq_before_clr", 32'(irq), 1);
    apb_write(32'h04, 32'h200, err);
    chk("flt_irq_after_clr", 32'(irq), 0);
    apb_read(32'h04, rd, err); chk("flt_status_clr", rd, 32'h2);
    apb_write(32'h00, 32'h2, err);
    apb_write(32'h0C, 32'h5, err);
    chk("err_seed_busy", 32'(err), 1);
    repeat (20) @(posedge clk);
    apb_read(32'h0C, rd, err); chk("err_seed_kept", rd, 1);
    apb_read(32'h38, rd, err);
    chk("err_sig2_slverr", 32'(err), 1);
    chk("err_sig2_data", rd, 0);
    apb_read(32'h44, rd, err); chk("err_unmapped", 32'(err), 1);
    apb_write(32'h08, 0, err);
    apb_write(32'h00, 32'h2, err);
    watch(10, 0, 0);
    chk("p0_busy_cycles", busy_cnt, 5);
    chk("p0_done_cycle", done_at, 5);
    apb_read(32'h30, rd, err); chk("p0_sig0", rd, 0);
    apb_read(32'h34, rd, err); chk("p0_sig1", rd, 0);
    apb_write(32'h04, 32'hF02, err);
    apb_write(32'h08, 4, err);
    apb_write(32'h0C, 0, err);
    apb_write(32'h00, 32'h2, err);
    watch(20, 0, 0);
    chk("s0_op_a", opa_h[2], 32'h1);
    chk("s0_op_b", opb_h[2], 32'h80000000);
    apb_read(32'h30, rd, err); chk("s0_sig0", rd, 32'h50C0000A);
    apb_read(32'h34, rd, err); chk("s0_sig1", rd, 32'h50000005);
    apb_read(32'h04, rd, err); chk("s0_status", rd, 32'h2);
    apb_write(32'h04, 32'h2, err);
    apb_write(32'h08, 100, err);
    apb_write(32'h00, 32'h1, err);
    @(negedge clk);
    sleep = 1'b1;
    @(posedge clk);
    #1;
    watch(60, 0, 50);
    chk("ab_busy_cycles", busy_cnt, 50);
    chk("ab_no_done", done_at, 0);
    apb_read(32'h04, rd, err); chk("ab_status", rd, 0);
    apb_read(32'h30, rd, err); chk("ab_sig0", rd, 32'h50C0000A);
    apb_write(32'h08, 4, err);
    @(negedge clk);
    paddr = 32'h00; pwdata = 32'h3; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    sleep = 1'b1;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    watch(20, 0, 3);
    chk("sim_busy_cycles", busy_cnt, 13);
    chk("sim_done_cycle", done_at, 13);
    apb_read(32'h04, rd, err); chk("sim_status", rd, 32'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ibex_lbist_mc_ctrl.md
Name: ibex_lbist_mc_ctrl

Overview:
- Parametrised multi-channel logic-BIST controller for execution-stage datapaths (ALU, branch-target adder, multdiv adder).
- Generates LFSR patterns and tests NumCh units-under-test one after another, round-robin from channel 0. Each channel's responses are compacted into its own MISR and compared against an APB-programmed golden signature.
- A run is triggered by core sleep entry or by a software write; the block raises an error IRQ on any mismatch.
- Sits beside the EX block on the peripheral APB.

Parameters:
- NumCh, 2, number of units under test (1..4).
- Width, 32, pattern/response/signature width (8..32).
- OpW, 4, width of the operator-select pattern field (1..6).
- LfsrPoly, 32'h80200003, Galois LFSR/MISR feedback taps, low Width bits used.
- AbortOnWake, 1, abort sleep-triggered runs when core_sleep_i falls.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- core_sleep_i  in  1  core sleep indication
- sim_fault_inject_i  in  1  simulation fault injection, flips response bit 0
- paddr_i  in  32  APB address, low 8 bits decoded
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- pwrite_i  in  1  APB write
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready, constant 1
- pslverr_o  out  1  APB error
- bist_active_o  out  1  UUT inputs muxed to BIST patterns
- bist_ch_o  out  2  channel under test
- bist_op_a_o  out  Width  pattern operand A
- bist_op_b_o  out  Width  pattern operand B
- bist_opsel_o  out  OpW  pattern operator select
- bist_resp_i  in  NumCh*Width  UUT results, combinational, channel c at [c*Width +: Width]
- bist_done_o  out  1  one-cycle pulse at run completion
- bist_error_irq_o  out  1  level interrupt

Behaviour:
- Reset: all outputs 0; CTRL=0, STATUS=0, PCNT=256, SEED=1, GOLDEN=0, SIG=0, FSM IDLE.
- Register map, APB access completes when psel&penable:
  - 0x00 CTRL rw: [0] EN (hardware trigger enable), [1] START (write-1 pulse, reads 0), [2] IRQ_EN.
  - 0x04 STATUS: [0] BUSY ro, [1] DONE w1c, [11:8] FAIL w1c, one bit per channel.
  - 0x08 PCNT rw: [15:0] patterns per channel.
  - 0x0C SEED rw.
  - 0x20+4c GOLDEN[c] rw.
  - 0x30+4c SIG[c] ro.
- Registers are Width wide and zero-extended on read.
- pslverr_o=1 (no state change, read data 0) on:
  - unmapped address, or c>=NumCh;
  - any write to CTRL, PCNT, SEED or GOLDEN while BUSY.
- STATUS w1c is always accepted.
- Triggers (evaluated only in IDLE):
  - START write starts a software run.
  - Rising edge of core_sleep_i with EN=1 starts a hardware run.
  - If both occur in the same cycle, the run is software (never aborted).
- FSM:
  - IDLE -> SEED on trigger.
  - SEED (1 cycle): LFSR<=SEED (0 replaced by 1); MISR<=0; ch=current channel.
  - SEED -> RUN if PCNT!=0, else CHECK.
  - RUN (exactly PCNT cycles): each cycle, outputs = op_a=LFSR, op_b=bit-reverse(LFSR), opsel=LFSR[OpW-1:0].
    - MISR <= shl1(MISR) ^ (MISR[Width-1] ? LfsrPoly : 0) ^ resp_c ^ {.., sim_fault_inject_i}.
    - LFSR advances one Galois step.
  - CHECK (1 cycle): SIG[ch]<=MISR; FAIL[ch]|=(MISR!=GOLDEN[ch]).
    - CHECK -> SEED for ch+1 if ch<NumCh-1, else DONE.
  - DONE (1 cycle): STATUS.DONE<=1, bist_done_o=1 -> IDLE.
- Run length = NumCh*(PCNT+2)+1 cycles from trigger acceptance.
- bist_active_o=1 and BUSY=1 in every state except IDLE; bist_ch_o=ch while active, else 0. Pattern outputs are 0 outside RUN.
- Abort: in a hardware run with AbortOnWake=1, core_sleep_i=0 in any non-IDLE cycle -> IDLE next cycle.
  - Abort leaves no SIG/FAIL/DONE update for unfinished channels; channels already checked keep their results.
  - bist_done_o is not pulsed.
- bist_error_irq_o = IRQ_EN & |FAIL, registered, one cycle after the FAIL update. It clears the cycle after the w1c of the FAIL bits.
- FAIL/DONE are sticky across runs until cleared; SIG is overwritten per channel.
- Reset mid-run: immediate IDLE, all registers reset.

Test Plan:
- Nominal pass: NumCh=2, PCNT=4, SEED=1, responses = op_a^op_b, GOLDEN from model, START -> BUSY for 13 cycles, done pulse on cycle 13, FAIL=0, irq=0, SIG matches model.
- Fault: same setup, IRQ_EN=1, sim_fault_inject_i=1 for one RUN cycle of channel 1 -> FAIL=4'b0010, irq high from the cycle after channel 1 CHECK; w1c 0x200 to STATUS -> irq low next cycle.
- Sleep trigger/abort: EN=1, PCNT=100, raise core_sleep_i, drop it at cycle 50 -> IDLE at cycle 51, no done pulse, SIG[0] unchanged, BUSY=0.
- Edge values: PCNT=0 -> SIG=0 on all channels, run length NumCh*2+1; SEED=0 -> patterns identical to SEED=1.
- APB errors: write SEED while BUSY -> pslverr=1, SEED unchanged; read 0x38 with NumCh=2 -> pslverr=1, data 0; read 0x44 -> pslverr=1.
- Simultaneous triggers: START write and sleep rising edge in the same cycle with EN=1, then sleep drops -> run completes, DONE=1.
